// File: rtl/ps2_pkg.sv
// Shared constants, scancodes and state types for the PS/2 move decoder.
// ARROW_KEYS_EN (see ps2_move_decoder) selects whether the arrow codes below are decoded.
package ps2_pkg;

   localparam logic [1:0] MOVE_NEG  = 2'd0;
   localparam logic [1:0] MOVE_POS  = 2'd1;
   localparam logic [1:0] MOVE_STOP = 2'd2;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      FR_IDLE,
      FR_DATA,
      FR_PARITY,
      FR_STOP
   } frame_state_t;

   typedef enum logic [1:0] {
      DEC_NORMAL,
      DEC_BREAK,
      DEC_EXT,
      DEC_EXT_BREAK
   } dec_state_t;

   // Opposing keys cancel to stop.
   function automatic logic [1:0] move_dir(input logic neg, input logic pos);
      if (neg && !pos)      return MOVE_NEG;
      else if (pos && !neg) return MOVE_POS;
      else                  return MOVE_STOP;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, 11-bit frame FSM with
// odd-parity/stop checking and an inter-edge timeout that drops partial frames.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] scanCode,
   output logic       codeValid,
   output logic       rxErr
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [SS-1:0] r_clk_sync, r_data_sync;
   logic          r_clk_prev;
   logic          w_clk_s, w_bit, w_fall;

   frame_state_t  r_state, w_state_nx;
   logic [7:0]    r_shift, w_shift_nx;
   logic [2:0]    r_bitcnt, w_bitcnt_nx;
   logic          r_parity, w_parity_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [7:0]    w_code_nx;
   logic          w_valid_nx, w_err_nx;

   // Pins idle high, so the synchroniser resets to ones to avoid a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SS-2:0], ps2Clk};
         r_data_sync <= {r_data_sync[SS-2:0], ps2Data};
         r_clk_prev  <= w_clk_s;
      end
   end

   assign w_clk_s = r_clk_sync[SS-1];
   assign w_bit   = r_data_sync[SS-1];
   assign w_fall  = r_clk_prev & ~w_clk_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FR_IDLE;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_parity  <= 1'b0;
         r_cnt     <= '0;
         scanCode  <= '0;
         codeValid <= 1'b0;
         rxErr     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_shift   <= w_shift_nx;
         r_bitcnt  <= w_bitcnt_nx;
         r_parity  <= w_parity_nx;
         r_cnt     <= w_cnt_nx;
         scanCode  <= w_code_nx;
         codeValid <= w_valid_nx;
         rxErr     <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_shift_nx  = r_shift;
      w_bitcnt_nx = r_bitcnt;
      w_parity_nx = r_parity;
      w_cnt_nx    = w_fall ? '0 : r_cnt + CW'(1);
      w_code_nx   = scanCode;
      w_valid_nx  = 1'b0;
      w_err_nx    = 1'b0;

      case (r_state)
         FR_IDLE: begin
            w_cnt_nx = '0;
            if (w_fall && !w_bit) begin
               w_state_nx  = FR_DATA;
               w_bitcnt_nx = '0;
            end
         end
         FR_DATA: begin
            if (w_fall) begin
               w_shift_nx  = {w_bit, r_shift[7:1]};
               w_bitcnt_nx = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) w_state_nx = FR_PARITY;
            end
         end
         FR_PARITY: begin
            if (w_fall) begin
               w_parity_nx = w_bit;
               w_state_nx  = FR_STOP;
            end
         end
         FR_STOP: begin
            if (w_fall) begin
               w_state_nx = FR_IDLE;
               if (w_bit && (^{r_shift, r_parity})) begin
                  w_code_nx  = r_shift;
                  w_valid_nx = 1'b1;
               end else begin
                  w_err_nx = 1'b1;
               end
            end
         end
         default: w_state_nx = FR_IDLE;
      endcase

      // A stalled keyboard must not leave the receiver wedged mid-frame.
      if (r_state != FR_IDLE && !w_fall && r_cnt == TO_MAX) begin
         w_state_nx = FR_IDLE;
         w_cnt_nx   = '0;
         w_err_nx   = 1'b1;
      end
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to moveX/moveY command decoder (WASD, plus E0 arrow keys when the
// ARROW_KEYS_EN macro is defined). Frame reception lives in ps2_frame_rx.
module ps2_move_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [1:0] moveX,
   output logic [1:0] moveY,
   output logic [7:0] scanCode,
   output logic       codeValid,
   output logic       rxErr
);

   dec_state_t r_dec, w_dec_nx;
   logic r_up, r_dn, r_lf, r_rt;
   logic w_up_nx, w_dn_nx, w_lf_nx, w_rt_nx;
   logic w_up_any, w_dn_any, w_lf_any, w_rt_any;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2Clk    (ps2Clk),
      .ps2Data   (ps2Data),
      .scanCode  (scanCode),
      .codeValid (codeValid),
      .rxErr     (rxErr)
   );

`ifdef ARROW_KEYS_EN
   logic r_aup, r_adn, r_alf, r_art;
   logic w_aup_nx, w_adn_nx, w_alf_nx, w_art_nx;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dec <= DEC_NORMAL;
         r_up  <= 1'b0;
         r_dn  <= 1'b0;
         r_lf  <= 1'b0;
         r_rt  <= 1'b0;
`ifdef ARROW_KEYS_EN
         r_aup <= 1'b0;
         r_adn <= 1'b0;
         r_alf <= 1'b0;
         r_art <= 1'b0;
`endif
         moveX <= MOVE_STOP;
         moveY <= MOVE_STOP;
      end else begin
         r_dec <= w_dec_nx;
         r_up  <= w_up_nx;
         r_dn  <= w_dn_nx;
         r_lf  <= w_lf_nx;
         r_rt  <= w_rt_nx;
`ifdef ARROW_KEYS_EN
         r_aup <= w_aup_nx;
         r_adn <= w_adn_nx;
         r_alf <= w_alf_nx;
         r_art <= w_art_nx;
`endif
         // Driven from next-state flags so moves land the cycle after codeValid.
         moveX <= move_dir(w_lf_any, w_rt_any);
         moveY <= move_dir(w_up_any, w_dn_any);
      end
   end

   always_comb begin
      w_dec_nx = r_dec;
      w_up_nx  = r_up;
      w_dn_nx  = r_dn;
      w_lf_nx  = r_lf;
      w_rt_nx  = r_rt;
`ifdef ARROW_KEYS_EN
      w_aup_nx = r_aup;
      w_adn_nx = r_adn;
      w_alf_nx = r_alf;
      w_art_nx = r_art;
`endif
      if (codeValid) begin
         w_dec_nx = DEC_NORMAL;
         case (r_dec)
            DEC_NORMAL: begin
               if (scanCode == SC_BREAK)    w_dec_nx = DEC_BREAK;
               else if (scanCode == SC_EXT) w_dec_nx = DEC_EXT;
               else begin
                  case (scanCode)
                     SC_W:    w_up_nx = 1'b1;
                     SC_S:    w_dn_nx = 1'b1;
                     SC_A:    w_lf_nx = 1'b1;
                     SC_D:    w_rt_nx = 1'b1;
                     default: ;
                  endcase
               end
            end
            DEC_BREAK: begin
               case (scanCode)
                  SC_W:    w_up_nx = 1'b0;
                  SC_S:    w_dn_nx = 1'b0;
                  SC_A:    w_lf_nx = 1'b0;
                  SC_D:    w_rt_nx = 1'b0;
                  default: ;
               endcase
            end
            DEC_EXT: begin
               if (scanCode == SC_BREAK) w_dec_nx = DEC_EXT_BREAK;
`ifdef ARROW_KEYS_EN
               else begin
                  case (scanCode)
                     SC_UP:    w_aup_nx = 1'b1;
                     SC_DOWN:  w_adn_nx = 1'b1;
                     SC_LEFT:  w_alf_nx = 1'b1;
                     SC_RIGHT: w_art_nx = 1'b1;
                     default:  ;
                  endcase
               end
`endif
            end
            DEC_EXT_BREAK: begin
`ifdef ARROW_KEYS_EN
               case (scanCode)
                  SC_UP:    w_aup_nx = 1'b0;
                  SC_DOWN:  w_adn_nx = 1'b0;
                  SC_LEFT:  w_alf_nx = 1'b0;
                  SC_RIGHT: w_art_nx = 1'b0;
                  default:  ;
               endcase
`endif
            end
            default: w_dec_nx = DEC_NORMAL;
         endcase
      end
   end

`ifdef ARROW_KEYS_EN
   assign w_up_any = w_up_nx | w_aup_nx;
   assign w_dn_any = w_dn_nx | w_adn_nx;
   assign w_lf_any = w_lf_nx | w_alf_nx;
   assign w_rt_any = w_rt_nx | w_art_nx;
`else
   assign w_up_any = w_up_nx;
   assign w_dn_any = w_dn_nx;
   assign w_lf_any = w_lf_nx;
   assign w_rt_any = w_rt_nx;
`endif

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_move_decoder;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [1:0] moveX, moveY;
   logic [7:0] scanCode;
   logic       codeValid, rxErr;

   int n_vec = 0;
   int n_err = 0;
   int n_cv  = 0;
   int n_re  = 0;
   int cv0, re0;

   ps2_move_decoder #(
      .TIMEOUT_CYCLES (TO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2Clk    (ps2Clk),
      .ps2Data   (ps2Data),
      .moveX     (moveX),
      .moveY     (moveY),
      .scanCode  (scanCode),
      .codeValid (codeValid),
      .rxErr     (rxErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (codeValid) n_cv++;
      if (rxErr)     n_re++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2Data = b;
      repeat (4) @(posedge clk);
      ps2Clk = 1'b0;
      repeat (8) @(posedge clk);
      ps2Clk = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   // Sends the first n bits of a frame {stop, parity, data, start}.
   task automatic send_bits(input logic [7:0] d, input logic par_flip, input logic stop, input int n);
      logic [10:0] f;
      f = {stop, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < n; i++) ps2_bit(f[i]);
      ps2Data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      send_bits(d, par_flip, stop, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic key(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b1);
   endtask

   task automatic mark;
      cv0 = n_cv;
      re0 = n_re;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_moveX", moveX, 2);
      chk("rst_moveY", moveY, 2);
      chk("rst_scan", scanCode, 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cv", codeValid, 0);
      chk("rst_err", rxErr, 0);

      // Good W frame, then reset dropped on a half-received frame.
      mark();
      key(8'h1D);
      chk("w_scan", scanCode, 8'h1D);
      chk("w_cv_cnt", n_cv - cv0, 1);
      chk("w_moveY", moveY, 0);
      chk("w_moveX", moveX, 2);
      send_bits(8'h1B, 1'b0, 1'b1, 5);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_moveY", moveY, 2);
      chk("midrst_scan", scanCode, 0);
      chk("midrst_cv", codeValid, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      mark();
      key(8'h1D);
      chk("post_rst_scan", scanCode, 8'h1D);
      chk("post_rst_moveY", moveY, 0);
      chk("post_rst_moveX", moveX, 2);
      chk("post_rst_err", n_re - re0, 0);

      // Release W.
      key(8'hF0);
      key(8'h1D);
      chk("w_rel_moveY", moveY, 2);

      // A then D, release A.
      key(8'h1C);
      chk("a_moveX", moveX, 0);
      key(8'h23);
      chk("ad_moveX", moveX, 2);
      key(8'hF0);
      key(8'h1C);
      chk("d_moveX", moveX, 1);
      key(8'h1C);
      key(8'h1C);
      chk("typematic_moveX", moveX, 2);
      key(8'hF0);
      key(8'h1C);
      key(8'hF0);
      key(8'h23);
      chk("all_rel_moveX", moveX, 2);
      key(8'hF0);
      key(8'h1B);
      chk("stray_break_moveY", moveY, 2);

      // Bad parity and bad stop.
      mark();
      send_frame(8'h1B, 1'b1, 1'b1);
      chk("par_err_cnt", n_re - re0, 1);
      chk("par_cv_cnt", n_cv - cv0, 0);
      chk("par_moveY", moveY, 2);
      mark();
      send_frame(8'h1B, 1'b0, 1'b0);
      chk("stop_err_cnt", n_re - re0, 1);
      chk("stop_cv_cnt", n_cv - cv0, 0);
      chk("stop_moveY", moveY, 2);

      // A lone start bit of 1 is ignored.
      mark();
      ps2_bit(1'b1);
      repeat (TO + 20) @(posedge clk);
      chk("idle_hi_err", n_re - re0, 0);

      // Timeout after 5 bits, then a clean D.
      mark();
      send_bits(8'h1B, 1'b0, 1'b1, 5);
      repeat (TO + 20) @(posedge clk);
      @(negedge clk);
      chk("to_err_cnt", n_re - re0, 1);
      chk("to_cv_cnt", n_cv - cv0, 0);
      mark();
      key(8'h23);
      chk("to_d_moveX", moveX, 1);
      chk("to_d_cv_cnt", n_cv - cv0, 1);
      chk("to_d_err_cnt", n_re - re0, 0);
      key(8'hF0);
      key(8'h23);
      chk("to_d_rel", moveX, 2);

      // Extended keys.
      key(8'hE0);
      key(8'h75);
`ifdef ARROW_KEYS_EN
      chk("arrow_up_moveY", moveY, 0);
`else
      chk("arrow_up_moveY", moveY, 2);
`endif
      key(8'hE0);
      key(8'hF0);
      key(8'h75);
      chk("arrow_rel_moveY", moveY, 2);
      key(8'h1D);
      key(8'hE0);
      key(8'hF0);
      key(8'h1D);
      chk("ext_break_w_moveY", moveY, 0);
      key(8'hF0);
      key(8'h1D);
      chk("final_moveY", moveY, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
